// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: core width, FSM state
// encodings, error codes and frame word positions.
package prog_loader_pkg;

  // Data/address width of the overlay core the loader feeds.
  localparam int RV_BIT_NUM = 32;

  // Frame header word positions.
  localparam int WORD_PC = 0;
  localparam int WORD_N  = 1;
  localparam int WORD_M  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_N   = 3'd1,
    ST_HDR_M   = 3'd2,
    ST_LD_IMEM = 3'd3,
    ST_LD_DMEM = 3'd4,
    ST_CHK     = 3'd5,
    ST_RUN     = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_N_BIG      = 2'd1,
    ERR_M_BIG      = 2'd2,
    ERR_PC_OR_SUM  = 2'd3
  } err_code_t;

endpackage

// File: rtl/prog_loader_chksum.sv
// Payload checksum: 32-bit wrapping sum with clear and accumulate enable.
// match compares the incoming word against the running sum.
module prog_loader_chksum
  import prog_loader_pkg::*;
#(
  parameter int XLEN = RV_BIT_NUM
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            acc_en,
  input  logic [XLEN-1:0] data,
  output logic            match
);

  logic [XLEN-1:0] sum_q;

  // Running sum; clear wins over accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
    end else if (acc_en) begin
      sum_q <= sum_q + data;
    end
  end

  assign match = (data == sum_q);

endmodule

// File: rtl/prog_loader.sv
// Host-side program loader: parses PC/N/M header, streams N words to imem
// and M words to dmem, then releases the core at pc_start_minus4.
// Optional trailer checksum enabled by defining PROG_LOADER_CHKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int              XLEN       = RV_BIT_NUM,
  parameter logic [XLEN-1:0] IMEM_BASE  = '0,
  parameter logic [XLEN-1:0] DMEM_BASE  = '0,
  parameter int              IMEM_WORDS = 4096,
  parameter int              DMEM_WORDS = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] host_data_i,
  input  logic            host_valid_i,
  output logic            host_ready_o,
  input  logic            host_clear_i,
  output logic [XLEN-1:0] imem_wr_addr,
  output logic [XLEN-1:0] imem_wr_data,
  output logic            imem_wr_valid,
  output logic [XLEN-1:0] dmem_wr_addr,
  output logic [XLEN-1:0] dmem_wr_data,
  output logic            dmem_wr_valid,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_start_minus4,
  output logic            busy_o,
  output logic            err_o,
  output logic [1:0]      err_code_o
);

  localparam int MAX_WORDS = (IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS;
  localparam int CNT_W     = $clog2(MAX_WORDS) + 1;
  localparam logic [XLEN-1:0] IMEM_LIM = XLEN'(IMEM_WORDS);
  localparam logic [XLEN-1:0] DMEM_LIM = XLEN'(DMEM_WORDS);
`ifdef PROG_LOADER_CHKSUM_EN
  localparam state_t ST_DONE = ST_CHK;
`else
  localparam state_t ST_DONE = ST_RUN;
`endif

  state_t           state_q, state_d;
  err_code_t        err_code_q, err_code_d;
  logic [XLEN-1:0]  pc_q;
  logic [CNT_W-1:0] n_q, m_q, cnt_q;
  logic             accept, last_imem, last_dmem, sum_match;

  assign accept    = host_valid_i & host_ready_o;
  assign last_imem = (cnt_q == n_q - CNT_W'(1));
  assign last_dmem = (cnt_q == m_q - CNT_W'(1));

`ifdef PROG_LOADER_CHKSUM_EN
  prog_loader_chksum #(.XLEN(XLEN)) u_chksum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (host_clear_i | (state_q == ST_IDLE)),
    .acc_en (accept & ((state_q == ST_LD_IMEM) | (state_q == ST_LD_DMEM))),
    .data   (host_data_i),
    .match  (sum_match)
  );
`else
  assign sum_match = 1'b0;
`endif

  // State and latched error code register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state: frame parsing and limit checks; clear overrides everything.
  // NOTE: defaults first in always_comb so no path leaves a variable unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    if (host_clear_i) begin
      state_d    = ST_IDLE;
      err_code_d = ERR_NONE;
    end else if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (host_data_i[1:0] != 2'b00) begin
            state_d    = ST_ERR;
            err_code_d = ERR_PC_OR_SUM;
          end else begin
            state_d = ST_HDR_N;
          end
        end
        ST_HDR_N: begin
          if (host_data_i > IMEM_LIM) begin
            state_d    = ST_ERR;
            err_code_d = ERR_N_BIG;
          end else begin
            state_d = ST_HDR_M;
          end
        end
        ST_HDR_M: begin
          if (host_data_i > DMEM_LIM) begin
            state_d    = ST_ERR;
            err_code_d = ERR_M_BIG;
          end else if (n_q != '0) begin
            state_d = ST_LD_IMEM;
          end else if (host_data_i != '0) begin
            state_d = ST_LD_DMEM;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_LD_IMEM: if (last_imem) state_d = (m_q != '0) ? ST_LD_DMEM : ST_DONE;
        ST_LD_DMEM: if (last_dmem) state_d = ST_DONE;
        ST_CHK: begin
          if (sum_match) begin
            state_d = ST_RUN;
          end else begin
            state_d    = ST_ERR;
            err_code_d = ERR_PC_OR_SUM;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; ready is also gated by clear and reset.
  always_comb begin
    host_ready_o    = 1'b0;
    busy_o          = 1'b0;
    pc_valid_o      = 1'b0;
    err_o           = 1'b0;
    pc_start_minus4 = '0;
    case (state_q)
      ST_IDLE: host_ready_o = 1'b1;
      ST_HDR_N, ST_HDR_M, ST_LD_IMEM, ST_LD_DMEM, ST_CHK: begin
        host_ready_o = 1'b1;
        busy_o       = 1'b1;
      end
      ST_RUN: begin
        pc_valid_o      = 1'b1;
        pc_start_minus4 = pc_q - XLEN'(4);
      end
      ST_ERR:  err_o = 1'b1;
      default: ;
    endcase
    host_ready_o = host_ready_o & ~host_clear_i & rst_n;
  end

  assign err_code_o = err_code_q;

  // Header latches, word counter and registered memory write ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= '0;
      n_q           <= '0;
      m_q           <= '0;
      cnt_q         <= '0;
      imem_wr_valid <= 1'b0;
      imem_wr_addr  <= '0;
      imem_wr_data  <= '0;
      dmem_wr_valid <= 1'b0;
      dmem_wr_addr  <= '0;
      dmem_wr_data  <= '0;
    end else begin
      imem_wr_valid <= 1'b0;
      dmem_wr_valid <= 1'b0;
      if (host_clear_i) begin
        pc_q  <= '0;
        n_q   <= '0;
        m_q   <= '0;
        cnt_q <= '0;
      end else if (accept) begin
        case (state_q)
          ST_IDLE:  pc_q <= host_data_i;
          ST_HDR_N: n_q  <= host_data_i[CNT_W-1:0];
          ST_HDR_M: m_q  <= host_data_i[CNT_W-1:0];
          ST_LD_IMEM: begin
            imem_wr_valid <= 1'b1;
            imem_wr_addr  <= IMEM_BASE + XLEN'({cnt_q, 2'b00});
            imem_wr_data  <= host_data_i;
            cnt_q         <= last_imem ? '0 : cnt_q + CNT_W'(1);
          end
          ST_LD_DMEM: begin
            dmem_wr_valid <= 1'b1;
            dmem_wr_addr  <= DMEM_BASE + XLEN'({cnt_q, 2'b00});
            dmem_wr_data  <= host_data_i;
            cnt_q         <= last_dmem ? '0 : cnt_q + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
